// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM init-sequence monitor: command encodings,
// error codes, FSM state encoding and mode register field positions.
package sdram_pkg;

    // {CS#, RAS#, CAS#, WE#}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_EARLY   = 3'd1;
    localparam logic [2:0] ERR_ORDER   = 3'd2;
    localparam logic [2:0] ERR_TIMING  = 3'd3;
    localparam logic [2:0] ERR_PREBANK = 3'd4;
    localparam logic [2:0] ERR_MRSBANK = 3'd5;
    localparam logic [2:0] ERR_MODE    = 3'd6;

    typedef enum logic [2:0] {
        S_PWR  = 3'd0,
        S_PRE  = 3'd1,
        S_TRP  = 3'd2,
        S_TRFC = 3'd3,
        S_TMRD = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    // Mode register / address field positions
    localparam int MR_BL_LSB = 0;   // A2..A0 burst length
    localparam int MR_BT_BIT = 3;   // A3 burst type
    localparam int MR_CL_LSB = 4;   // A6..A4 CAS latency
    localparam int MR_WS_BIT = 9;   // A9 write burst mode
    localparam int AP_BIT    = 10;  // A10 all-banks on PRE

    // Deselect (CS#=1) behaves exactly like a NOP.
    function automatic logic cmd_is_nop(input logic [3:0] cmd);
        return cmd[3] || (cmd == CMD_NOP);
    endfunction

    // Legal mode register contents for the optional MRS value check.
    function automatic logic mode_legal(input logic [12:0] a);
        logic [2:0] cl;
        logic [2:0] bl;
        logic       bt;
        logic       rsv_ok;
        logic       cl_ok;
        logic       bl_ok;
        cl     = a[MR_CL_LSB +: 3];
        bl     = a[MR_BL_LSB +: 3];
        bt     = a[MR_BT_BIT];
        rsv_ok = (a[12:10] == 3'b000) && !a[8] && !a[7];
        cl_ok  = (cl == 3'b010) || (cl == 3'b011);
        bl_ok  = (bl <= 3'b011) || ((bl == 3'b111) && !bt);
        return rsv_ok && cl_ok && bl_ok;
    endfunction

endpackage

// File: rtl/sdram_init_mon_if.sv
// Pin bundle between an SDRAM init sequencer (master) and the monitor (slave).
interface sdram_init_mon_if;

    logic [3:0]  mon_cmd;
    logic [1:0]  mon_bank;
    logic [12:0] mon_addr;
    logic        mon_done;
    logic        mon_err;
    logic [2:0]  mon_err_code;
    logic [2:0]  mon_cas_lat;
    logic        mon_burst_type;
    logic [2:0]  mon_burst_len;
    logic        mon_wr_single;
    logic [3:0]  mon_ar_cnt;

    modport master (
        output mon_cmd, mon_bank, mon_addr,
        input  mon_done, mon_err, mon_err_code, mon_cas_lat,
               mon_burst_type, mon_burst_len, mon_wr_single, mon_ar_cnt
    );

    modport slave (
        input  mon_cmd, mon_bank, mon_addr,
        output mon_done, mon_err, mon_err_code, mon_cas_lat,
               mon_burst_type, mon_burst_len, mon_wr_single, mon_ar_cnt
    );

endinterface

// File: rtl/sdram_gap_cnt.sv
// Saturating NOP counter with clear-on-command. Exposes both the registered
// count and its next value so the caller can act on the edge that reaches a
// threshold.
module sdram_gap_cnt #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] SAT   = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic [WIDTH-1:0] cnt_nxt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear wins over increment; hold once saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/sdram_init_mon.sv
// SDRAM power-up sequence monitor. Decodes the command pins, tracks the
// PWR -> PRE -> AR* -> MRS -> DONE sequence, enforces NOP gaps, latches the
// mode register and records the first violation.
// Optional MRS value check: define SDRAM_INIT_MON_MODE_CHK_EN.
//
// state  | meaning
// S_PWR  | power-up wait, counting NOPs up to CNT_WAIT
// S_PRE  | waiting for precharge-all
// S_TRP  | after PRE, waiting for tRP then the first AR
// S_TRFC | after AR, waiting for tRFC then AR/PRE/MRS
// S_TMRD | after MRS, waiting for tMRD NOPs
// S_DONE | init complete, commands ignored
// S_ERR  | violation recorded, held until reset
module sdram_init_mon
    import sdram_pkg::*;
#(
    parameter logic [15:0] CNT_WAIT = 16'd10000,
    parameter logic [3:0]  TRP      = 4'd3,
    parameter logic [3:0]  TRFC     = 4'd7,
    parameter logic [3:0]  TMRD     = 4'd2,
    parameter logic [3:0]  CNT_AR   = 4'd2
) (
    input logic              mon_clk,
    input logic              mon_rst,
    sdram_init_mon_if.slave  mon_bus
);

    state_t      state_q;
    logic        done_q;
    logic        err_q;
    logic [2:0]  err_code_q;
    logic [2:0]  cas_lat_q;
    logic        burst_type_q;
    logic [2:0]  burst_len_q;
    logic        wr_single_q;
    logic [3:0]  ar_cnt_q;

    logic        cmd_nop;
    logic        is_pre;
    logic        is_ar;
    logic        is_mrs;
    logic        mode_ok;
    logic [2:0]  viol;
    logic [15:0] pwr_cnt;
    logic [15:0] pwr_nxt;
    logic [3:0]  gap_cnt;
    logic [3:0]  gap_nxt;

    assign cmd_nop = cmd_is_nop(mon_bus.mon_cmd);
    assign is_pre  = (mon_bus.mon_cmd == CMD_PRE);
    assign is_ar   = (mon_bus.mon_cmd == CMD_AR);
    assign is_mrs  = (mon_bus.mon_cmd == CMD_MRS);

`ifdef SDRAM_INIT_MON_MODE_CHK_EN
    assign mode_ok = mode_legal(mon_bus.mon_addr);
`else
    logic unused_addr;
    assign mode_ok     = 1'b1;
    assign unused_addr = ^{mon_bus.mon_addr[12:11], mon_bus.mon_addr[8:7]};
`endif

    // Power-up NOP count; never cleared by commands, only by reset.
    sdram_gap_cnt #(
        .WIDTH (16),
        .SAT   (CNT_WAIT)
    ) u_pwr_cnt (
        .clk_i     (mon_clk),
        .rst_i     (mon_rst),
        .clr_i     (1'b0),
        .inc_i     (cmd_nop),
        .cnt_o     (pwr_cnt),
        .cnt_nxt_o (pwr_nxt)
    );

    // NOP gap since the last real command.
    sdram_gap_cnt #(
        .WIDTH (4),
        .SAT   (4'd15)
    ) u_gap_cnt (
        .clk_i     (mon_clk),
        .rst_i     (mon_rst),
        .clr_i     (!cmd_nop),
        .inc_i     (cmd_nop),
        .cnt_o     (gap_cnt),
        .cnt_nxt_o (gap_nxt)
    );

    // Classify the sampled command against the current state; ERR_NONE means legal.
    always_comb begin
        viol = ERR_NONE;
        case (state_q)
            S_PWR: begin
                if (!cmd_nop && (pwr_cnt < CNT_WAIT)) viol = ERR_EARLY;
            end
            S_PRE: begin
                if (is_pre) begin
                    if (!mon_bus.mon_addr[AP_BIT]) viol = ERR_PREBANK;
                end else if (!cmd_nop) begin
                    viol = ERR_ORDER;
                end
            end
            S_TRP: begin
                if (!cmd_nop) begin
                    if (gap_cnt < TRP)  viol = ERR_TIMING;
                    else if (!is_ar)    viol = ERR_ORDER;
                end
            end
            S_TRFC: begin
                if (!cmd_nop) begin
                    if (gap_cnt < TRFC) begin
                        viol = ERR_TIMING;
                    end else if (is_mrs) begin
                        if (mon_bus.mon_bank != 2'b00) viol = ERR_MRSBANK;
                        else if (ar_cnt_q < CNT_AR)    viol = ERR_ORDER;
                        else if (!mode_ok)             viol = ERR_MODE;
                    end else if (is_pre) begin
                        if (!mon_bus.mon_addr[AP_BIT]) viol = ERR_PREBANK;
                    end else if (!is_ar) begin
                        viol = ERR_ORDER;
                    end
                end
            end
            S_TMRD: begin
                if (!cmd_nop) viol = ERR_TIMING;
            end
            default: viol = ERR_NONE;
        endcase
    end

    // Sequence FSM with registered status and latched mode fields.
    always_ff @(posedge mon_clk) begin
        if (mon_rst) begin
            state_q      <= S_PWR;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            cas_lat_q    <= 3'd0;
            burst_type_q <= 1'b0;
            burst_len_q  <= 3'd0;
            wr_single_q  <= 1'b0;
            ar_cnt_q     <= 4'd0;
        end else if (viol != ERR_NONE) begin
            state_q    <= S_ERR;
            err_q      <= 1'b1;
            err_code_q <= viol;
        end else begin
            case (state_q)
                S_PWR: begin
                    if (cmd_nop && (pwr_nxt >= CNT_WAIT)) state_q <= S_PRE;
                end
                S_PRE: begin
                    if (is_pre) state_q <= S_TRP;
                end
                S_TRP: begin
                    if (is_ar) begin
                        state_q <= S_TRFC;
                        if (ar_cnt_q != 4'hF) ar_cnt_q <= ar_cnt_q + 4'd1;
                    end
                end
                S_TRFC: begin
                    if (is_ar) begin
                        if (ar_cnt_q != 4'hF) ar_cnt_q <= ar_cnt_q + 4'd1;
                    end else if (is_pre) begin
                        state_q <= S_TRP;
                    end else if (is_mrs) begin
                        state_q      <= S_TMRD;
                        cas_lat_q    <= mon_bus.mon_addr[MR_CL_LSB +: 3];
                        burst_type_q <= mon_bus.mon_addr[MR_BT_BIT];
                        burst_len_q  <= mon_bus.mon_addr[MR_BL_LSB +: 3];
                        wr_single_q  <= mon_bus.mon_addr[MR_WS_BIT];
                    end
                end
                S_TMRD: begin
                    if (cmd_nop && (gap_nxt >= TMRD)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign mon_bus.mon_done       = done_q;
    assign mon_bus.mon_err        = err_q;
    assign mon_bus.mon_err_code   = err_code_q;
    assign mon_bus.mon_cas_lat    = cas_lat_q;
    assign mon_bus.mon_burst_type = burst_type_q;
    assign mon_bus.mon_burst_len  = burst_len_q;
    assign mon_bus.mon_wr_single  = wr_single_q;
    assign mon_bus.mon_ar_cnt     = ar_cnt_q;

endmodule

// File: tb/tb_sdram_init_mon.sv
// Testbench for sdram_init_mon: scenario tasks push expected status snapshots
// onto a scoreboard queue as stimulus is driven and compare when sampled.
module tb_sdram_init_mon;
    import sdram_pkg::*;

    typedef struct packed {
        logic       done;
        logic       err;
        logic [2:0] code;
        logic [2:0] cas;
        logic       bt;
        logic [2:0] bl;
        logic       ws;
        logic [3:0] ar;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t sb[$];
    obs_t e_v;
    obs_t o_v;

    sdram_init_mon_if bus ();

    sdram_init_mon dut (
        .mon_clk (clk),
        .mon_rst (rst),
        .mon_bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    function automatic obs_t observe();
        obs_t o;
        o.done = bus.mon_done;
        o.err  = bus.mon_err;
        o.code = bus.mon_err_code;
        o.cas  = bus.mon_cas_lat;
        o.bt   = bus.mon_burst_type;
        o.bl   = bus.mon_burst_len;
        o.ws   = bus.mon_wr_single;
        o.ar   = bus.mon_ar_cnt;
        return o;
    endfunction

    function automatic obs_t mk(input logic done, input logic err, input logic [2:0] code,
                                input logic [2:0] cas, input logic bt, input logic [2:0] bl,
                                input logic ws, input logic [3:0] ar);
        obs_t o;
        o.done = done; o.err = err; o.code = code; o.cas = cas;
        o.bt = bt; o.bl = bl; o.ws = ws; o.ar = ar;
        return o;
    endfunction

    // Drive one command for one cycle; outputs are sampled 1 ns after the edge.
    task automatic send(input logic [3:0] cmd, input logic [1:0] bank, input logic [12:0] addr);
        bus.mon_cmd  = cmd;
        bus.mon_bank = bank;
        bus.mon_addr = addr;
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) send(CMD_NOP, 2'b00, 13'h0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nops(2);
        rst = 1'b0;
    endtask

    // Power wait, PRE-all, tRP, AR, tRFC, AR, tRFC: leaves the DUT ready for MRS.
    task automatic to_mrs_ready();
        nops(10000);
        send(CMD_PRE, 2'b00, 13'h0400);
        nops(3);
        send(CMD_AR, 2'b00, 13'h0000);
        nops(7);
        send(CMD_AR, 2'b00, 13'h0000);
        nops(7);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sb.push_back(mk(0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 4'd0));
        nops(3);
        e_v = sb.pop_front(); o_v = observe(); n_tests++;
        if (o_v !== e_v) begin n_fail++; $display("FAIL reset: got %h required %h", o_v, e_v); end
        rst = 1'b0;
    endtask

    task automatic test_early();
        do_reset();
        nops(5000);
        sb.push_back(mk(0, 1, ERR_EARLY, 3'd0, 0, 3'd0, 0, 4'd0));
        send(CMD_PRE, 2'b00, 13'h0400);
        nops(2);
        e_v = sb.pop_front(); o_v = observe(); n_tests++;
        if (o_v !== e_v) begin n_fail++; $display("FAIL early: got %h required %h", o_v, e_v); end
    endtask

    task automatic test_timing();
        do_reset();
        nops(10000);
        sb.push_back(mk(0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 4'd0));
        send(CMD_PRE, 2'b00, 13'h0400);
        e_v = sb.pop_front(); o_v = observe(); n_tests++;
        if (o_v !== e_v) begin n_fail++; $display("FAIL timing_pre_ok: got %h required %h", o_v, e_v); end
        nops(2);
        sb.push_back(mk(0, 1, ERR_TIMING, 3'd0, 0, 3'd0, 0, 4'd0));
        send(CMD_AR, 2'b00, 13'h0000);
        nops(1);
        e_v = sb.pop_front(); o_v = observe(); n_tests++;
        if (o_v !== e_v) begin n_fail++; $display("FAIL timing_trp: got %h required %h", o_v, e_v); end
    endtask

    task automatic test_order();
        do_reset();
        nops(10000);
        send(CMD_PRE, 2'b00, 13'h0400);
        nops(3);
        sb.push_back(mk(0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 4'd1));
        send(CMD_AR, 2'b00, 13'h0000);
        e_v = sb.pop_front(); o_v = observe(); n_tests++;
        if (o_v !== e_v) begin n_fail++; $display("FAIL order_ar1: got %h required %h", o_v, e_v); end
        nops(7);
        sb.push_back(mk(0, 1, ERR_ORDER, 3'd0, 0, 3'd0, 0, 4'd1));
        send(CMD_MRS, 2'b00, 13'h0037);
        nops(2);
        e_v = sb.pop_front(); o_v = observe(); n_tests++;
        if (o_v !== e_v) begin n_fail++; $display("FAIL order_mrs: got %h required %h", o_v, e_v); end
    endtask

    task automatic test_prebank();
        do_reset();
        nops(10000);
        sb.push_back(mk(0, 1, ERR_PREBANK, 3'd0, 0, 3'd0, 0, 4'd0));
        send(CMD_PRE, 2'b00, 13'h0000);
        nops(1);
        e_v = sb.pop_front(); o_v = observe(); n_tests++;
        if (o_v !== e_v) begin n_fail++; $display("FAIL prebank: got %h required %h", o_v, e_v); end
    endtask

    task automatic test_mrsbank();
        do_reset();
        to_mrs_ready();
        sb.push_back(mk(0, 1, ERR_MRSBANK, 3'd0, 0, 3'd0, 0, 4'd2));
        send(CMD_MRS, 2'b01, 13'h0037);
        nops(2);
        e_v = sb.pop_front(); o_v = observe(); n_tests++;
        if (o_v !== e_v) begin n_fail++; $display("FAIL mrsbank: got %h required %h", o_v, e_v); end
    endtask

    task automatic test_reset_replay();
        do_reset();
        nops(10000);
        send(CMD_PRE, 2'b00, 13'h0400);
        nops(3);
        send(CMD_AR, 2'b00, 13'h0000);
        nops(3);
        rst = 1'b1;
        sb.push_back(mk(0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 4'd0));
        nops(1);
        e_v = sb.pop_front(); o_v = observe(); n_tests++;
        if (o_v !== e_v) begin n_fail++; $display("FAIL replay_reset: got %h required %h", o_v, e_v); end
        rst = 1'b0;
        // Nominal sequence from a clean restart.
        to_mrs_ready();
        sb.push_back(mk(0, 0, 3'd0, 3'd3, 0, 3'd7, 0, 4'd2));
        send(CMD_MRS, 2'b00, 13'h0037);
        e_v = sb.pop_front(); o_v = observe(); n_tests++;
        if (o_v !== e_v) begin n_fail++; $display("FAIL nominal_mrs: got %h required %h", o_v, e_v); end
        sb.push_back(mk(0, 0, 3'd0, 3'd3, 0, 3'd7, 0, 4'd2));
        nops(1);
        e_v = sb.pop_front(); o_v = observe(); n_tests++;
        if (o_v !== e_v) begin n_fail++; $display("FAIL nominal_tmrd1: got %h required %h", o_v, e_v); end
        sb.push_back(mk(1, 0, 3'd0, 3'd3, 0, 3'd7, 0, 4'd2));
        nops(1);
        e_v = sb.pop_front(); o_v = observe(); n_tests++;
        if (o_v !== e_v) begin n_fail++; $display("FAIL nominal_done: got %h required %h", o_v, e_v); end
        // Commands after done are ignored.
        sb.push_back(mk(1, 0, 3'd0, 3'd3, 0, 3'd7, 0, 4'd2));
        send(CMD_AR, 2'b00, 13'h0000);
        send(4'b0011, 2'b00, 13'h0000);
        nops(1);
        e_v = sb.pop_front(); o_v = observe(); n_tests++;
        if (o_v !== e_v) begin n_fail++; $display("FAIL done_ignore: got %h required %h", o_v, e_v); end
    endtask

    task automatic test_mode();
        do_reset();
        to_mrs_ready();
`ifdef SDRAM_INIT_MON_MODE_CHK_EN
        sb.push_back(mk(0, 1, ERR_MODE, 3'd0, 0, 3'd0, 0, 4'd2));
`else
        sb.push_back(mk(1, 0, 3'd0, 3'd1, 0, 3'd7, 0, 4'd2));
`endif
        send(CMD_MRS, 2'b00, 13'h0017);
        nops(2);
        e_v = sb.pop_front(); o_v = observe(); n_tests++;
        if (o_v !== e_v) begin n_fail++; $display("FAIL mode_cl1: got %h required %h", o_v, e_v); end
    endtask

    initial begin
        bus.mon_cmd  = CMD_NOP;
        bus.mon_bank = 2'b00;
        bus.mon_addr = 13'h0000;
        test_reset();
        test_early();
        test_timing();
        test_order();
        test_prebank();
        test_mrsbank();
        test_reset_replay();
        test_mode();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
